// File: rtl/flow_led_ctrl.sv
// LED pattern sequencer: prescaled step strobe driving rotate, bounce and fill-bar patterns.
// state | meaning
// UP    | bounce LED moving toward bit LED_NUM-1 (also the idle value in other modes)
// DOWN  | bounce LED moving toward bit 0
module flow_led_ctrl #(
    parameter  int LED_NUM     = 4,
    parameter  int STEP_CYCLES = 10_000_000,
    localparam int CNT_W       = $clog2(STEP_CYCLES)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0]         MODE_FILL = 2'b11;
    localparam logic [LED_NUM-1:0] LED_ONE   = {{(LED_NUM-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]   r_cnt;
    logic [LED_NUM-1:0] r_led;
    dir_t               r_dir;
    logic [1:0]         r_mode_q;
    logic               r_step_pulse;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LED_NUM-1:0] w_led_nxt;
    dir_t               w_dir_nxt;
    logic [1:0]         w_mode_nxt;
    logic               w_pulse_nxt;

    logic [31:0]        w_period;
    logic               w_tick;
    logic               w_onehot;
    logic               w_thermo;
    logic               w_full;
    logic [LED_NUM-1:0] w_adv_led;
    dir_t               w_adv_dir;
    logic [LED_NUM-1:0] w_init_led;

    // >= rather than == so a mid-count speed increase ticks at once instead of wrapping
    assign w_period   = 32'(STEP_CYCLES) >> speed;
    assign w_tick     = en && (32'(r_cnt) >= (w_period - 32'd1));

    assign w_onehot   = (r_led != '0) && ((r_led & (r_led - 1'b1)) == '0);
    assign w_thermo   = (r_led & (r_led + 1'b1)) == '0;
    assign w_full     = &r_led;
    assign w_init_led = (mode == MODE_FILL) ? '0 : LED_ONE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt        <= '0;
            r_led        <= LED_ONE;
            r_dir        <= DIR_UP;
            r_mode_q     <= 2'b00;
            r_step_pulse <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_led        <= w_led_nxt;
            r_dir        <= w_dir_nxt;
            r_mode_q     <= w_mode_nxt;
            r_step_pulse <= w_pulse_nxt;
        end
    end

    // One step of the latched mode; illegal patterns fall back to the mode's initial value.
    always_comb begin
        w_adv_led = LED_ONE;
        w_adv_dir = DIR_UP;
        case (r_mode_q)
            2'b00: begin
                if (w_onehot) w_adv_led = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
            end
            2'b01: begin
                if (w_onehot) w_adv_led = {r_led[0], r_led[LED_NUM-1:1]};
            end
            2'b10: begin
                if (w_onehot) begin
                    if (r_dir == DIR_UP) begin
                        if (r_led[LED_NUM-1]) begin
                            w_adv_led = r_led >> 1;
                            w_adv_dir = DIR_DOWN;
                        end else begin
                            w_adv_led = r_led << 1;
                            w_adv_dir = DIR_UP;
                        end
                    end else begin
                        if (r_led[0]) begin
                            w_adv_led = r_led << 1;
                            w_adv_dir = DIR_UP;
                        end else begin
                            w_adv_led = r_led >> 1;
                            w_adv_dir = DIR_DOWN;
                        end
                    end
                end
            end
            default: begin
                if (!w_thermo || w_full) w_adv_led = '0;
                else                     w_adv_led = {r_led[LED_NUM-2:0], 1'b1};
            end
        endcase
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_led_nxt   = r_led;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode_q;
        w_pulse_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt  = '0;
            w_mode_nxt = mode;
            w_dir_nxt  = DIR_UP;
            w_led_nxt  = w_init_led;
        end else if (w_tick) begin
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b1;
            // a mode change spends its step loading the new start pattern
            if (mode != r_mode_q) begin
                w_mode_nxt = mode;
                w_dir_nxt  = DIR_UP;
                w_led_nxt  = w_init_led;
            end else begin
                w_dir_nxt  = w_adv_dir;
                w_led_nxt  = w_adv_led;
            end
        end else if (en) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_comb begin
        led        = r_led;
        step_pulse = r_step_pulse;
    end

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Scoreboard bench for flow_led_ctrl: stimulus queues expected steps and snapshots, monitor checks them.
module tb_flow_led_ctrl;
    localparam int N = 4;

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         en        = 1'b1;
    logic         clr       = 1'b0;
    logic [1:0]   mode      = 2'b00;
    logic [1:0]   speed     = 2'b00;
    logic [N-1:0] led;
    logic         step_pulse;

    typedef struct {
        logic [N-1:0] led;
        int           at;
    } step_t;

    typedef struct {
        logic [N-1:0] led;
        logic         pulse;
        string        tag;
    } snap_t;

    step_t step_q[$];
    snap_t snap_q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    bit    done  = 1'b0;

    flow_led_ctrl #(.LED_NUM(N), .STEP_CYCLES(8)) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .en         (en),
        .clr        (clr),
        .mode       (mode),
        .speed      (speed),
        .led        (led),
        .step_pulse (step_pulse)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic cyc_step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) cyc_step(1);
    endtask

    task automatic exp_step(input logic [N-1:0] l, input int at);
        step_t s;
        s.led = l;
        s.at  = at;
        step_q.push_back(s);
    endtask

    task automatic exp_snap(input logic [N-1:0] l, input logic p, input string tag);
        snap_t s;
        s.led   = l;
        s.pulse = p;
        s.tag   = tag;
        snap_q.push_back(s);
    endtask

    task automatic restart(input logic [1:0] md, output int m);
        sys_rst_n = 1'b0;
        cyc_step(2);
        mode      = md;
        speed     = 2'b00;
        en        = 1'b1;
        clr       = 1'b0;
        sys_rst_n = 1'b1;
        m         = cyc;
    endtask

    // stimulus
    initial begin
        int m;
        logic [N-1:0] rl [4];
        logic [N-1:0] rr [5];
        logic [N-1:0] bo [8];
        logic [N-1:0] fb [6];
        rl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        bo = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        fb = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};

        cyc_step(2);
        exp_snap(4'b0001, 1'b0, "reset_state");
        cyc_step(1);
        sys_rst_n = 1'b1;
        m = cyc;
        for (int i = 0; i < 4; i++) exp_step(rl[i], m + 8 * (i + 1));
        wait_until(m + 33);

        restart(2'b01, m);
        for (int i = 0; i < 5; i++) exp_step(rr[i], m + 8 * (i + 1));
        wait_until(m + 41);

        restart(2'b10, m);
        for (int i = 0; i < 8; i++) exp_step(bo[i], m + 8 * (i + 1));
        wait_until(m + 65);

        restart(2'b11, m);
        for (int i = 0; i < 6; i++) exp_step(fb[i], m + 8 * (i + 1));
        exp_step(4'b0001, m + 54);
        exp_step(4'b0011, m + 56);
        exp_step(4'b0111, m + 58);
        exp_step(4'b1111, m + 60);
        exp_step(4'b0000, m + 62);
        wait_until(m + 53);
        speed = 2'd2;
        wait_until(m + 62);
        speed = 2'd0;
        exp_step(4'b0001, m + 70);
        wait_until(m + 73);
        en = 1'b0;
        wait_until(m + 93);
        en = 1'b1;
        exp_step(4'b0011, m + 98);
        wait_until(m + 101);
        clr = 1'b1;
        cyc_step(1);
        clr = 1'b0;
        exp_snap(4'b0000, 1'b0, "clr_load");
        exp_step(4'b0001, m + 110);
        wait_until(m + 111);

        restart(2'b10, m);
        for (int i = 0; i < 5; i++) exp_step(bo[i], m + 8 * (i + 1));
        wait_until(m + 43);
        sys_rst_n = 1'b0;
        exp_snap(4'b0001, 1'b0, "async_reset");
        cyc_step(3);
        sys_rst_n = 1'b1;
        m = cyc;
        exp_step(4'b0001, m + 8);
        exp_step(4'b0010, m + 16);
        wait_until(m + 20);
        done = 1'b1;
    end

    // monitor
    initial begin
        snap_t s;
        step_t st;
        forever begin
            @(negedge sys_clk);
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                total++;
                if (led !== s.led || step_pulse !== s.pulse) begin
                    bad++;
                    $display("FAIL %s: led=%b step_pulse=%b, required led=%b step_pulse=%b",
                             s.tag, led, step_pulse, s.led, s.pulse);
                end
            end
            if (step_pulse === 1'b1) begin
                total++;
                if (step_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_step: led=%b at cycle %0d, required no step", led, cyc);
                end else begin
                    st = step_q.pop_front();
                    if (led !== st.led || cyc != st.at) begin
                        bad++;
                        $display("FAIL step: led=%b at cycle %0d, required led=%b at cycle %0d",
                                 led, cyc, st.led, st.at);
                    end
                end
            end
            if (done || cyc > 5000) begin
                total++;
                if (!done || step_q.size() != 0 || snap_q.size() != 0) begin
                    bad++;
                    $display("FAIL pending_checks: steps=%0d snaps=%0d finished=%0d, required 0 0 1",
                             step_q.size(), snap_q.size(), done);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule

// File: doc/flow_led_ctrl.md
Name: flow_led_ctrl

Overview:
Parametrised LED pattern sequencer for the board LED bank. It generalises the fixed 4-LED left-rotating chaser: any LED count, a programmable step period with run-time speed select, four display modes, pause, and synchronous restart. It sits between the top-level clock/reset and the LED pins, and exports a step strobe that other demo logic can use.

Parameters:
LED_NUM, 4, number of LEDs driven; legal range 2..32.
STEP_CYCLES, 10_000_000, sys_clk cycles per step at speed 0; must be >= 8.
CNT_W, $clog2(STEP_CYCLES), width of the prescaler counter (derived, not overridden).

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
en  in  1  1 = run, 0 = pause (prescaler and pattern frozen)
clr  in  1  synchronous restart of prescaler and pattern; has priority over en
mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 fill-bar
speed  in  2  step period = STEP_CYCLES >> speed
led  out  LED_NUM  LED drive, bit i = LED i, active-high
step_pulse  out  1  one-cycle strobe, high in the cycle led takes a new value

Behaviour:
- Reset value of every output: led = 1 in bit 0 only; step_pulse = 0. Internal values: cnt = 0, mode_q = 00, dir = up.
- Prescaler: period P = STEP_CYCLES >> speed.
  - When en = 1, cnt increments each cycle.
  - tick = en && (cnt >= P-1). On tick, cnt returns to 0.
  - The >= compare makes a speed increase mid-count tick on the next cycle, with no long wrap.
  - When en = 0, cnt holds and no tick occurs.
- Pattern update happens on the clock edge after the cycle where tick = 1. On that same edge step_pulse is set to 1. In all other cycles step_pulse is 0.
- Mode latch: mode is sampled only at tick.
  - If mode != mode_q: set mode_q <= mode, load the initial pattern of the new mode, set dir = up. No advance occurs on this step.
  - Otherwise: advance the pattern by one step in mode_q.
- Initial patterns: modes 00, 01 and 10 start with bit 0 set. Mode 11 starts with all zeros.
- Rotate-left (00): led <= {led[N-2:0], led[N-1]}. The MSB wraps to bit 0.
- Rotate-right (01): led <= {led[0], led[N-1:1]}. Bit 0 wraps to the MSB.
- Bounce (10): a single LED moves one position per step in direction dir.
  - Reaching bit N-1 while moving up: on the next step go to bit N-2 and set dir = down.
  - Reaching bit 0 while moving down: on the next step go to bit 1 and set dir = up.
  - No LED is ever repeated at an endpoint. Cycle length is 2N-2 steps.
- Fill-bar (11): led <= {led[N-2:0], 1'b1} until all ones; the step after all ones gives all zeros. Cycle length is N+1 steps.
- Corrupt-pattern recovery: if led ever holds an illegal value for modes 00/01/10 (zero, or more than one bit set), the next step loads the initial pattern. Fill-bar treats any non-thermometer value the same way.
- clr = 1 (synchronous, priority over en and tick), on the next edge:
  - cnt = 0, mode_q = mode, dir = up;
  - led = initial pattern of the current mode input;
  - step_pulse = 0.
- en = 0 while tick is pending: nothing happens. Once en returns to 1, counting resumes from the held cnt.
- Asynchronous reset mid-step immediately forces the reset values. The first tick after release comes P cycles after the first enabled edge.
- All arithmetic is unsigned. cnt never exceeds P-1 in steady state, except transiently after a speed change, which the >= compare covers.

Test Plan:
- Bench setup: LED_NUM = 4, STEP_CYCLES = 8.
- Rotate-left: reset release, en = 1, mode = 00, speed = 0 -> step_pulse every 8 cycles; led sequence 0001, 0010, 0100, 1000, 0001.
- Rotate-right and bounce:
  - mode = 01 from reset -> first tick loads 0001 (mode change); then 1000, 0100, 0010, 0001.
  - mode = 10 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Fill-bar and speed change:
  - mode = 11 -> 0000, 0001, 0011, 0111, 1111, 0000.
  - Switch speed to 2 when cnt = 5 -> tick on the next cycle; afterwards step_pulse every 2 cycles.
- Pause and clear:
  - en = 0 for 20 cycles mid-step -> led and cnt are unchanged and step_pulse stays 0; after resume, the remaining count finishes the step.
  - clr pulse with mode = 11 -> led = 0000 and cnt = 0 on the next edge; the next tick comes 8 cycles later.
- Mid-operation reset: assert sys_rst_n = 0 asynchronously in bounce mode with led = 0100 and dir = down -> led = 0001 and step_pulse = 0 immediately. After release, with mode = 10 held, the first tick loads 0001 (mode change from 00), then 0010.
